// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states, iteration count.
// Optional feature macro: MULDIV_MADD_EN (enables madd/msub accumulate).
package muldiv_pkg;

   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = $clog2(ITER_COUNT);

   typedef enum logic [1:0] {
      OP_MULT = 2'b00,
      OP_DIV  = 2'b01,
      OP_MADD = 2'b10,
      OP_MSUB = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_CALC   = 2'b01,
      ST_FINISH = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/partial registers and one shift-add (mult) or restoring-subtract (div) step per cycle.
// Ports: clk, reset, load/step controls, op/srcA/srcB, acc (HI:LO, MULDIV_MADD_EN only), result.
module muldiv_datapath
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [1:0]  op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
`ifdef MULDIV_MADD_EN
   input  logic [63:0] acc,
`endif
   output logic [63:0] result
);

   op_e         op_q;
   logic [31:0] opa_q;
   logic [31:0] opb_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] hi_nx;
   logic [31:0] lo_nx;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;

   // mult: hi accumulates, lo holds the multiplier and shifts right.
   // div: hi is the partial remainder, lo shifts dividend out and quotient in.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : 33'd0);
      div_shift = {hi_q, lo_q[31]};
      div_diff  = div_shift - {1'b0, opb_q};
      if (op_q == OP_DIV) begin
         if (div_diff[32]) begin
            hi_nx = div_shift[31:0];
            lo_nx = {lo_q[30:0], 1'b0};
         end else begin
            hi_nx = div_diff[31:0];
            lo_nx = {lo_q[30:0], 1'b1};
         end
      end else begin
         hi_nx = mul_sum[32:1];
         lo_nx = {mul_sum[0], lo_q[31:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q  <= OP_MULT;
         opa_q <= '0;
         opb_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else if (load) begin
         op_q  <= op_e'(op);
         opa_q <= srcA;
         opb_q <= srcB;
         hi_q  <= '0;
         lo_q  <= (op_e'(op) == OP_DIV) ? srcA : srcB;
      end else if (step) begin
         hi_q <= hi_nx;
         lo_q <= lo_nx;
      end
   end

`ifdef MULDIV_MADD_EN
   always_comb begin
      unique case (op_q)
         OP_MADD: result = acc + {hi_q, lo_q};
         OP_MSUB: result = acc - {hi_q, lo_q};
         default: result = {hi_q, lo_q};
      endcase
   end
`else
   assign result = {hi_q, lo_q};
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for 32-cycle mult/div/madd/msub with HI/LO registers and mthi/mtlo writes.
// Ports: clk, reset, start, op, srcA, srcB, hiWr, loWr, hiIn, loIn -> busy, done, divByZero, hi, lo.
// Optional feature macro: MULDIV_MADD_EN (madd/msub accumulate into HI:LO).
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic        hiWr,
   input  logic        loWr,
   input  logic [31:0] hiIn,
   input  logic [31:0] loIn,
   output logic        busy,
   output logic        done,
   output logic        divByZero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             dbz_q;
   logic             dbz_d;
   logic             busy_d;
   logic             done_d;
   logic             divByZero_d;
   logic [31:0]      hi_d;
   logic [31:0]      lo_d;
   logic             accept;
   logic             zero_div;
   logic             last;
   logic             fin;
   logic             idle_wr;
   logic [63:0]      result;

   assign accept   = (state_q == ST_IDLE) && start;
   assign zero_div = (op_e'(op) == OP_DIV) && (srcB == '0);
   assign last     = cnt_q == CNT_W'(ITER_COUNT - 1);
   assign fin      = state_q == ST_FINISH;
   assign idle_wr  = (state_q == ST_IDLE) && !start;

   muldiv_datapath u_dp (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .step   (state_q == ST_CALC),
      .op     (op),
      .srcA   (srcA),
      .srcB   (srcB),
`ifdef MULDIV_MADD_EN
      .acc    ({hi, lo}),
`endif
      .result (result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dbz_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         divByZero <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dbz_q     <= dbz_d;
         busy      <= busy_d;
         done      <= done_d;
         divByZero <= divByZero_d;
         hi        <= hi_d;
         lo        <= lo_d;
      end
   end

   // A zero divisor skips the iterations and goes straight to FINISH.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               dbz_d   = zero_div;
               cnt_d   = '0;
               state_d = zero_div ? ST_FINISH : ST_CALC;
            end
         end
         ST_CALC: begin
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_d      = state_d != ST_IDLE;
      done_d      = fin;
      divByZero_d = divByZero;
      hi_d        = hi;
      lo_d        = lo;
      unique case (1'b1)
         fin: begin
            divByZero_d = dbz_q;
            if (!dbz_q) begin
               hi_d = result[63:32];
               lo_d = result[31:0];
            end
         end
         idle_wr: begin
            if (hiWr) hi_d = hiIn;
            if (loWr) lo_d = loIn;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model plus directed vectors.
// Honours MULDIV_MADD_EN the same way as the design.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        hiWr;
   logic        loWr;
   logic [31:0] hiIn;
   logic [31:0] loIn;
   logic        busy;
   logic        done;
   logic        divByZero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   muldiv_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .srcA      (srcA),
      .srcB      (srcB),
      .hiWr      (hiWr),
      .loWr      (loWr),
      .hiIn      (hiIn),
      .loIn      (loIn),
      .busy      (busy),
      .done      (done),
      .divByZero (divByZero),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: operation result from plain arithmetic, timing as a cycle countdown.
   int          rem_cyc = 0;
   logic        m_busy;
   logic        m_done;
   logic        m_dbz;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [63:0] pend;
   logic        pend_dbz;
   logic [63:0] prod;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (reset) begin
         m_busy = 0; m_dbz = 0; m_hi = 0; m_lo = 0; rem_cyc = 0;
      end else if (rem_cyc > 0) begin
         rem_cyc--;
         if (rem_cyc == 0) begin
            m_busy = 0;
            m_done = 1;
            m_dbz  = pend_dbz;
            if (!pend_dbz) {m_hi, m_lo} = pend;
         end
      end else if (start) begin
         prod     = 64'(srcA) * 64'(srcB);
         pend     = prod;
         pend_dbz = 0;
         case (op)
            2'b01: begin
               if (srcB == 0) pend_dbz = 1;
               else pend = {srcA % srcB, srcA / srcB};
            end
`ifdef MULDIV_MADD_EN
            2'b10: pend = {m_hi, m_lo} + prod;
            2'b11: pend = {m_hi, m_lo} - prod;
`endif
            default: ;
         endcase
         m_busy  = 1;
         rem_cyc = pend_dbz ? 1 : 33;
      end else begin
         if (hiWr) m_hi = hiIn;
         if (loWr) m_lo = loIn;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("hi", 64'(hi), 64'(m_hi));
         check("lo", 64'(lo), 64'(m_lo));
         check("busy_done_excl", 64'(busy & done), 64'(0));
         if (m_done) check("divByZero", 64'(divByZero), 64'(m_dbz));
         if (done) done_cnt++;
      end
   end

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit wr);
      @(negedge clk);
      start = 1; op = o; srcA = a; srcB = b;
      hiWr = wr; hiIn = 32'hAAAA_5555;
      @(posedge clk);
      @(negedge clk);
      start = 0; hiWr = 0;
   endtask

   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = busy ? 1 : 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
      end
      check("done_seen", 64'(lat != 0), 64'(1));
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat, output int bcnt);
      launch(o, a, b, 1'b0);
      wait_done(lat, bcnt);
   endtask

   task automatic mt(input bit hw, input logic [31:0] hv, input bit lw, input logic [31:0] lv);
      @(negedge clk);
      hiWr = hw; hiIn = hv; loWr = lw; loIn = lv;
      @(posedge clk);
      @(negedge clk);
      hiWr = 0; loWr = 0;
   endtask

   int lat;
   int bcnt;
   int d0;

   initial begin
      reset = 1; start = 0; op = 0; srcA = 0; srcB = 0;
      hiWr = 0; loWr = 0; hiIn = 0; loIn = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset  = 0;
      chk_en = 1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_dbz", 64'(divByZero), 64'(0));
      check("rst_hilo", {hi, lo}, 64'(0));

      run_op(2'b00, 32'd7, 32'd6, lat, bcnt);
      check("mul7x6_lat", 64'(lat), 64'(33));
      check("mul7x6_busy", 64'(bcnt), 64'(33));
      check("mul7x6", {hi, lo}, 64'd42);
      check("mul7x6_dbz", 64'(divByZero), 64'(0));

      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      check("mul_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      run_op(2'b01, 32'd100, 32'd7, lat, bcnt);
      check("div100_7", {hi, lo}, {32'd2, 32'd14});
      check("div100_7_dbz", 64'(divByZero), 64'(0));

      run_op(2'b01, 32'd5, 32'd0, lat, bcnt);
      check("div0_lat", 64'(lat), 64'(1));
      check("div0_dbz", 64'(divByZero), 64'(1));
      check("div0_hilo", {hi, lo}, {32'd2, 32'd14});

      mt(1, 32'd0, 1, 32'd10);
      check("mt_hilo", {hi, lo}, 64'd10);
      run_op(2'b10, 32'd3, 32'd4, lat, bcnt);
      check("madd_dbz_clr", 64'(divByZero), 64'(0));
`ifdef MULDIV_MADD_EN
      check("madd", {hi, lo}, 64'd22);
      run_op(2'b11, 32'd5, 32'd5, lat, bcnt);
      check("msub", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
      check("madd_as_mult", {hi, lo}, 64'd12);
      run_op(2'b11, 32'd5, 32'd5, lat, bcnt);
      check("msub_as_mult", {hi, lo}, 64'd25);
`endif

      mt(1, 32'h1234_5678, 1, 32'h9ABC_DEF0);
      check("mt_both", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
      mt(0, 32'h0, 1, 32'h0000_0055);
      check("mtlo_only", {hi, lo}, 64'h1234_5678_0000_0055);

      // Second start and mthi while busy must be ignored.
      d0 = done_cnt;
      launch(2'b00, 32'd123, 32'd456, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1; op = 2'b01; srcA = 32'd9; srcB = 32'd3;
      hiWr = 1; hiIn = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      start = 0; hiWr = 0;
      wait_done(lat, bcnt);
      check("busy_ign", {hi, lo}, 64'd56088);
      repeat (40) @(negedge clk);
      check("busy_one_done", 64'(done_cnt - d0), 64'(1));

      // Reset in the middle of a divide.
      launch(2'b01, 32'd1000, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_hilo", {hi, lo}, 64'(0));
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      check("abort_no_done", 64'(done_cnt - d0), 64'(0));

      // start wins over mthi in IDLE.
      launch(2'b00, 32'd2, 32'd3, 1'b1);
      wait_done(lat, bcnt);
      check("mul2x3", {hi, lo}, 64'd6);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port start, input, 1: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2: operation code; 00 mult, 01 div, 10 madd, 11 msub; latched with start.
REQ-005 SHALL have port srcA, input, 32: operand A (multiplicand or dividend); latched with start.
REQ-006 SHALL have port srcB, input, 32: operand B (multiplier or divisor); latched with start.
REQ-007 SHALL have port hiWr, input, 1: mthi strobe; writes hiIn to HI.
REQ-008 SHALL have port loWr, input, 1: mtlo strobe; writes loIn to LO.
REQ-009 SHALL have port hiIn, input, 32: mthi data.
REQ-010 SHALL have port loIn, input, 32: mtlo data.
REQ-011 SHALL have port busy, output, 1: an operation is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port divByZero, output, 1: valid with done; set when a div had srcB == 0.
REQ-014 SHALL have port hi, output, 32: registered HI value.
REQ-015 SHALL have port lo, output, 32: registered LO value.

Function
REQ-016 SHALL implement FSM states IDLE, CALC and FINISH, with all outputs registered.
REQ-017 SHALL, in IDLE with start=1 at edge N, latch op, srcA and srcB, and enter CALC; busy=1 after edge N.
REQ-018 SHALL perform one iteration per edge N+1..N+32 using a 5-bit counter, then enter FINISH.
REQ-019 SHALL, at edge N+33, write HI/LO, pulse done=1 for one cycle, drop busy to 0, and return to IDLE.
REQ-020 SHALL compute mult as an unsigned shift-add: {hi,lo} = srcA*srcB, 64-bit product.
REQ-021 SHALL compute div as unsigned restoring division: lo = quotient, hi = remainder.
REQ-022 SHALL compute madd as {hi,lo} = {hi,lo} + srcA*srcB, mod 2^64, using HI/LO as held at start.
REQ-023 SHALL compute msub as {hi,lo} = {hi,lo} - srcA*srcB, mod 2^64, using HI/LO as held at start.
REQ-024 SHALL, for div with srcB == 0, skip CALC: done=1 and divByZero=1 after edge N+1, HI/LO unchanged, busy back to 0.
REQ-025 SHALL clear divByZero to 0 on every done pulse that is not a divide-by-zero.
REQ-026 SHALL ignore start while busy=1, with no effect on the operation in progress.
REQ-027 SHALL, in IDLE with start=0, apply hiWr/loWr at the next edge; both asserted together SHALL write both registers.
REQ-028 SHALL ignore hiWr/loWr while busy=1 or when asserted together with start in IDLE (start has priority).
REQ-029 SHALL never assert done and busy together.

Reset
REQ-030 SHALL, on reset=1 at any edge, set state=IDLE, busy=0, done=0, divByZero=0, hi=0, lo=0 and counter=0.
REQ-031 SHALL abort any operation in progress when reset is asserted mid-operation, with no done pulse.
REQ-032 SHALL give reset priority over start, hiWr and loWr.

Configuration
REQ-033 SHALL, with macro MULDIV_MADD_EN defined, support op 10 (madd) and 11 (msub) as specified in REQ-022 and REQ-023.
REQ-034 SHALL, without MULDIV_MADD_EN, execute op 10/11 as plain mult (HI/LO overwritten) and omit the 64-bit accumulate adder.

Structure
REQ-035 SHALL place op encodings (OP_MULT, OP_DIV, OP_MADD, OP_MSUB), FSM state encodings and ITER_COUNT=32 in shared package muldiv_pkg.
REQ-036 SHALL contain one sub-module, muldiv_datapath, holding the operand/partial registers and the per-iteration add/subtract-shift step.
REQ-037 SHALL keep the FSM, counter and handshake in muldiv_sequencer.

Verification
REQ-038 SHALL verify: mult 7 x 6 -> done exactly 33 cycles after start accepted, hi=0, lo=42, busy high for 33 cycles.
REQ-039 SHALL verify: mult 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 SHALL verify: div 100/7 -> lo=14, hi=2, divByZero=0; div 5/0 -> done 1 cycle after start, divByZero=1, HI/LO unchanged.
REQ-041 SHALL verify: loWr with loIn=10 and hiWr with hiIn=0, then madd 3 x 4 -> lo=22, hi=0; then msub 5 x 5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
REQ-042 SHALL verify: start again at cycle 5 of a mult and hiWr during busy -> both ignored, original result unchanged, a single done pulse.
REQ-043 SHALL verify: reset at cycle 10 of a div -> busy=0, hi=lo=0, no done pulse; a new mult 2 x 3 then gives lo=6.
